pio_uart_tx: RTL and testbench
==============================

Name: pio_uart_tx

Overview:
- Downstream consumer of the 32-bit Avalon PIO output word that HPS software writes over the lightweight AXI bridge.
- Software writes a data byte and flips a request toggle bit. The block detects the toggle and serialises the byte as an 8N1 (optionally parity) UART frame on txd.
- Returns a 32-bit status word for a companion input PIO, so software can poll busy, overrun and frame count.

Parameters:
- CLK_FREQ_HZ, 50000000, clk frequency in Hz.
- BAUD, 115200, line rate.
- PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.
- CLKS_PER_BIT, CLK_FREQ_HZ/BAUD (truncating; 434 at defaults), clk cycles per bit. Elaboration error if < 2.

Ports:
- clk  in  1  system clock, single domain.
- reset  in  1  synchronous, active-high reset.
- in_word  in  32  PIO output word.
  - [7:0] data byte.
  - [30] overrun clear, level-sensitive.
  - [31] request toggle.
  - [29:8] ignored.
- txd  out  1  serial output, idle high.
- status  out  32  status word.
  - [0] busy.
  - [1] overrun (sticky).
  - [15:8] tx_count.
  - all other bits 0.

Behaviour:
- Reset values:
  - txd = 1, busy = 0, overrun = 0, tx_count = 0.
  - State IDLE, in_q = 0, req_prev = 0, primed = 0.
- Input capture: in_q <= in_word every cycle. All decisions use in_q, never in_word directly.
- Priming: the first cycle after reset deassertion loads req_prev <= in_q[31] and sets primed = 1, with no request. A toggle bit left at 1 before reset therefore never sends a spurious byte.
- Request: when primed = 1 and in_q[31] != req_prev. req_prev <= in_q[31] on every primed cycle.
- Accept: request while state = IDLE.
  - Latch in_q[7:0].
  - Enter START; txd = 0 and busy = 1 from that same edge.
  - Latency: word presented before edge k, txd low after edge k+1.
- Reject: request while state != IDLE, including the final cycle of STOP.
  - Byte dropped; overrun <= 1.
  - In-flight frame unaffected.
- Overrun clear: while in_q[30] = 1, overrun is held 0. If set and clear coincide, clear wins.
- FSM states, each held exactly CLKS_PER_BIT cycles, driven by a bit counter 0..CLKS_PER_BIT-1:
  - IDLE: txd = 1.
  - START: txd = 0.
  - DATA: 8 bits, LSB first; a bit index 0..7 advances at each counter terminal.
  - PARITY: only when PARITY != 0. Even mode sends XOR of the 8 data bits; odd mode sends its inverse.
  - STOP: txd = 1.
- Transitions: IDLE -> START -> DATA(x8) -> [PARITY] -> STOP -> IDLE.
- Frame length: 10 (or 11 with parity) × CLKS_PER_BIT cycles from txd falling edge to return to IDLE.
- Frame completion, at the STOP counter terminal:
  - tx_count <= tx_count + 1, mod 256; 255 wraps to 0.
  - busy <= 0 on the same edge as the IDLE transition.
- Back-to-back: a toggle seen on the first IDLE cycle is accepted, giving minimum one idle-high cycle between frames.
- Reset mid-frame: frame aborted, txd = 1 on the edge where reset is sampled, tx_count not incremented, priming repeats.
- status and txd are registered outputs (no combinational path from in_word).

Decomposition:
- Package pio_uart_pkg holds:
  - State enum (IDLE, START, DATA, PARITY, STOP).
  - Field constants REQ_BIT = 31, CLR_BIT = 30, DATA_LSB = 0, DATA_W = 8.
  - Status bit positions BUSY_BIT = 0, OVR_BIT = 1, CNT_LSB = 8.
  - Parity encodings PAR_NONE / PAR_EVEN / PAR_ODD.
- One sub-module, pio_uart_baud_cnt:
  - Counts 0..CLKS_PER_BIT-1 while enabled, cleared when disabled.
  - Outputs a one-cycle terminal tick.
  - Top level holds the FSM, shift register, toggle detect and status.

Test Plan (CLK_FREQ_HZ = 1000, BAUD = 100, so CLKS_PER_BIT = 10):
- Reset held with in_word = 0x8000_0000, then released and held for 50 cycles -> txd stays 1, status = 0x0000_0000.
- From primed idle, write 0x0000_0055 then 0x8000_0055 -> txd low 2 edges after the change. Line shows 0,1,0,1,0,1,0,1,0,1, each 10 cycles. Then busy = 0 and status = 0x0000_0100.
- PARITY = 1, send 0x07 -> parity bit = 1 and frame is 110 cycles. PARITY = 2, same byte -> parity bit = 0.
- Second toggle 30 cycles into a frame -> first frame bit-exact, second byte never sent, status[1] = 1. Then write bit 30 = 1 -> status[1] = 0.
- 256 back-to-back frames, each toggle issued on the first IDLE cycle -> tx_count wraps to 0x00 and overrun stays 0.
- Reset asserted mid-DATA -> txd = 1 the next edge and tx_count unchanged. After release, one new toggle sends a complete frame.

Source files
------------

// File: rtl/pio_uart_tx_pkg.sv
// Shared types and field positions for the PIO-driven UART transmitter.
// Both the PIO word layout and the status word layout live here.
package pio_uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  localparam int REQ_BIT  = 31;
  localparam int CLR_BIT  = 30;
  localparam int DATA_LSB = 0;
  localparam int DATA_W   = 8;

  localparam int BUSY_BIT = 0;
  localparam int OVR_BIT  = 1;
  localparam int CNT_LSB  = 8;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Only the meaningful fields of the PIO word are kept in the capture register.
  typedef struct packed {
    logic              req;
    logic              clr;
    logic [DATA_W-1:0] data;
  } pio_cmd_t;

  function automatic logic par_bit(input logic [DATA_W-1:0] d, input int mode);
    return (mode == PAR_ODD) ? ~^d : ^d;
  endfunction

endpackage

// File: rtl/pio_uart_tx_if.sv
// PIO-side bundle: command word from software, serial line and status back.
interface pio_uart_tx_if;
  logic [31:0] in_word;
  logic        txd;
  logic [31:0] status;

  modport master (output in_word, input txd, input status);
  modport slave  (input in_word, output txd, output status);
endinterface

// File: rtl/pio_uart_baud_cnt.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 while enabled, held at 0 otherwise,
// with a single-cycle tick on the last count.
module pio_uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = en && (cnt_q == LAST);
    cnt_d = '0;
    if (en && !tick) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/pio_uart_tx.sv
// UART transmitter fed by an Avalon PIO word: a toggle of the request bit sends
// the data byte as an 8N1 (or 8E1/8O1) frame; busy/overrun/count are reported back.
module pio_uart_tx
  import pio_uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = 50_000_000,
  parameter int BAUD         = 115_200,
  parameter int PARITY       = PAR_NONE,
  parameter int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD
) (
  input logic        clk,
  input logic        reset,
  pio_uart_tx_if.slave bus
);
  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("pio_uart_tx: CLKS_PER_BIT must be at least 2");
  end

  localparam bit HAS_PAR = (PARITY != PAR_NONE);

  pio_cmd_t          in_q, in_d;
  logic              live_q, live_d;
  logic              primed_q, primed_d;
  logic              req_prev_q, req_prev_d;
  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic              par_q, par_d;
  logic              txd_q, txd_d;
  logic              busy_q, busy_d;
  logic              ovr_q, ovr_d;
  logic [7:0]        cnt_q, cnt_d;

  logic req, tick, baud_en, done;

  assign in_d = '{req:  bus.in_word[REQ_BIT],
                  clr:  bus.in_word[CLR_BIT],
                  data: bus.in_word[DATA_LSB +: DATA_W]};

  // live_q marks that in_q holds a real sample; priming waits for it so a
  // toggle bit already high across reset is absorbed instead of seen as an edge.
  assign live_d     = 1'b1;
  assign primed_d   = primed_q | live_q;
  assign req_prev_d = live_q ? in_q.req : req_prev_q;
  assign req        = primed_q && (in_q.req != req_prev_q);

  assign baud_en = (state_q != S_IDLE);
  assign done    = (state_q == S_STOP) && tick;

  pio_uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk   (clk),
    .reset (reset),
    .en    (baud_en),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      in_q       <= '0;
      live_q     <= 1'b0;
      primed_q   <= 1'b0;
      req_prev_q <= 1'b0;
      state_q    <= S_IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      par_q      <= 1'b0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      ovr_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      in_q       <= in_d;
      live_q     <= live_d;
      primed_q   <= primed_d;
      req_prev_q <= req_prev_d;
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      par_q      <= par_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
      ovr_q      <= ovr_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (req)  state_d = S_START;
      S_START:  if (tick) state_d = S_DATA;
      S_DATA:   if (tick && bit_idx_q == 3'd7) state_d = HAS_PAR ? S_PARITY : S_STOP;
      S_PARITY: if (tick) state_d = S_STOP;
      S_STOP:   if (tick) state_d = S_IDLE;
      default:            state_d = S_IDLE;
    endcase
  end

  // txd is computed from the next state so the line changes on the same edge
  // as the state, keeping it a clean registered output.
  always_comb begin
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    par_d     = par_q;
    if (state_q == S_IDLE && req) begin
      shift_d   = in_q.data;
      bit_idx_d = '0;
      par_d     = par_bit(in_q.data, PARITY);
    end else if (state_q == S_DATA && tick) begin
      shift_d   = shift_q >> 1;
      bit_idx_d = bit_idx_q + 3'd1;
    end

    unique case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shift_d[0];
      S_PARITY: txd_d = par_d;
      default:  txd_d = 1'b1;
    endcase

    busy_d = (state_d != S_IDLE);
    cnt_d  = cnt_q + {7'd0, done};
    ovr_d  = in_q.clr ? 1'b0 : (ovr_q | (req && state_q != S_IDLE));
  end

  always_comb begin
    bus.status                          = '0;
    bus.status[BUSY_BIT]                = busy_q;
    bus.status[OVR_BIT]                 = ovr_q;
    bus.status[CNT_LSB +: 8]            = cnt_q;
  end

  assign bus.txd = txd_q;

endmodule

// File: tb/tb_pio_uart_tx.sv
// Randomised bench for pio_uart_tx: three instances (no/even/odd parity) checked
// against a frame-level model of the serial line and status word.
module tb_pio_uart_tx;
  localparam int N = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pio_uart_tx_if if0(), if1(), if2();
  logic [31:0] in_w [3];
  assign if0.in_word = in_w[0];
  assign if1.in_word = in_w[1];
  assign if2.in_word = in_w[2];

  logic [2:0]  txd_w;
  logic [31:0] st_w [3];
  assign txd_w = {if2.txd, if1.txd, if0.txd};
  assign st_w[0] = if0.status;
  assign st_w[1] = if1.status;
  assign st_w[2] = if2.status;

  pio_uart_tx #(.CLK_FREQ_HZ(1000), .BAUD(100), .PARITY(0)) u0 (.clk(clk), .reset(reset), .bus(if0));
  pio_uart_tx #(.CLK_FREQ_HZ(1000), .BAUD(100), .PARITY(1)) u1 (.clk(clk), .reset(reset), .bus(if1));
  pio_uart_tx #(.CLK_FREQ_HZ(1000), .BAUD(100), .PARITY(2)) u2 (.clk(clk), .reset(reset), .bus(if2));

  int n_chk = 0, n_pass = 0, n_fail = 0;
  logic tog [3];
  int   cnt [3];
  bit   ovr [3];
  logic [7:0] bytes [256];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One frame on instance sel. pre: toggle already presented by the previous
  // frame; inj: cycle into the frame at which a second toggle is written (-1 none);
  // chain: present the next toggle (byte nb) during the last STOP cycle.
  task automatic xmit(input int sel, input logic [7:0] b, input bit pre,
                      input int inj, input bit chain, input logic [7:0] nb);
    bit exp_bits[$];
    int nbits, ones;
    exp_bits = {};
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
    ones = $countones(b);
    if (sel == 1) exp_bits.push_back((ones % 2) == 1);
    if (sel == 2) exp_bits.push_back((ones % 2) == 0);
    exp_bits.push_back(1'b1);
    nbits = exp_bits.size();

    if (!pre) begin
      @(negedge clk);
      tog[sel] = ~tog[sel];
      in_w[sel] = {tog[sel], 1'b0, 22'd0, b};
      @(posedge clk); #1;
    end
    chk("pre_txd", txd_w[sel], 1'b1);
    chk("pre_busy", st_w[sel][0], 1'b0);
    @(posedge clk); #1;
    chk("start_txd", txd_w[sel], 1'b0);
    chk("start_busy", st_w[sel][0], 1'b1);
    for (int c = 0; c < nbits * N; c++) begin
      if (c % N == N / 2) chk($sformatf("bit%0d_s%0d", c / N, sel), txd_w[sel], exp_bits[c / N]);
      if (c == nbits * N - 1) chk("busy_last", st_w[sel][0], 1'b1);
      if (c == inj) begin
        @(negedge clk);
        tog[sel] = ~tog[sel];
        in_w[sel] = {tog[sel], 1'b0, 22'd0, ~b};
        ovr[sel] = 1'b1;
      end
      if (chain && c == nbits * N - 1) begin
        @(negedge clk);
        tog[sel] = ~tog[sel];
        in_w[sel] = {tog[sel], 1'b0, 22'd0, nb};
      end
      @(posedge clk); #1;
    end
    cnt[sel] = (cnt[sel] + 1) % 256;
    chk("done_busy", st_w[sel][0], 1'b0);
    chk("done_txd", txd_w[sel], 1'b1);
    chk("count", st_w[sel][15:8], cnt[sel][7:0]);
    chk("overrun", st_w[sel][1], ovr[sel]);
    chk("status_rsvd", st_w[sel] & 32'hFFFF_00FC, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin cnt[i] = 0; ovr[i] = 1'b0; end
    repeat (5) @(posedge clk);
  endtask

  initial begin
    bit saw_low;
    for (int i = 0; i < 3; i++) begin
      in_w[i] = 32'h8000_0000; tog[i] = 1'b1; cnt[i] = 0; ovr[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // toggle bit high across reset must not send anything
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      chk("idle_txd", txd_w, 3'b111);
      chk("idle_status", st_w[0] | st_w[1] | st_w[2], 32'h0);
    end

    // data change without toggle, then the toggle
    @(negedge clk);
    in_w[0] = 32'h8000_0055;
    repeat (4) begin @(posedge clk); #1; chk("no_toggle_txd", txd_w[0], 1'b1); end
    xmit(0, 8'h55, 1'b0, -1, 1'b0, 8'h00);
    chk("status_after_55", st_w[0], 32'h0000_0100);

    xmit(1, 8'h07, 1'b0, -1, 1'b0, 8'h00);
    xmit(2, 8'h07, 1'b0, -1, 1'b0, 8'h00);

    for (int i = 0; i < 9; i++) begin
      repeat ($urandom_range(0, 4)) @(posedge clk);
      xmit(i % 3, 8'($urandom), 1'b0, -1, 1'b0, 8'h00);
    end

    // second toggle mid-frame is dropped and flagged
    xmit(0, 8'($urandom), 1'b0, 30, 1'b0, 8'h00);
    saw_low = 1'b0;
    repeat (3 * N) begin @(posedge clk); #1; if (txd_w[0] !== 1'b1) saw_low = 1'b1; end
    chk("no_second_frame", saw_low, 1'b0);
    chk("ovr_sticky", st_w[0][1], 1'b1);
    @(negedge clk);
    in_w[0][30] = 1'b1;
    repeat (2) @(posedge clk); #1;
    ovr[0] = 1'b0;
    chk("ovr_cleared", st_w[0][1], 1'b0);
    @(negedge clk);
    in_w[0][30] = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("ovr_stays_clear", st_w[0][1], 1'b0);

    // 256 back-to-back frames: count wraps, no overrun
    do_reset();
    for (int i = 0; i < 256; i++) bytes[i] = 8'($urandom);
    for (int i = 0; i < 256; i++)
      xmit(0, bytes[i], i > 0, -1, i < 255, (i < 255) ? bytes[(i + 1) % 256] : 8'h00);
    chk("wrap_zero", st_w[0][15:8], 8'h00);
    chk("wrap_no_ovr", st_w[0][1], 1'b0);

    // reset in the middle of the data bits
    repeat (3) @(posedge clk);
    @(negedge clk);
    tog[0] = ~tog[0];
    in_w[0] = {tog[0], 1'b0, 22'd0, 8'($urandom)};
    repeat (2 + N + 35) @(posedge clk); #1;
    chk("mid_busy", st_w[0][0], 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_txd", txd_w[0], 1'b1);
    chk("rst_busy", st_w[0][0], 1'b0);
    chk("rst_count", st_w[0][15:8], 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin cnt[i] = 0; ovr[i] = 1'b0; end
    saw_low = 1'b0;
    repeat (2 * N) begin @(posedge clk); #1; if (txd_w[0] !== 1'b1) saw_low = 1'b1; end
    chk("post_rst_quiet", saw_low, 1'b0);
    xmit(0, 8'($urandom), 1'b0, -1, 1'b0, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
